spi_target: RTL and testbench

- Byte-wide SPI target (slave), SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- It is the far end of the SoC's SPI master link and lets a second SoC, or a test board, act as the peripheral on sclk/mosi/miso/ssn.
- It oversamples all SPI pins with the system clock.
- The CPU side uses the same load/unload/datain/dataout strobe style as the master SPI block.

---
 rtl/spi_target.sv | 123 ++++++++++++
 tb/tb_spi_target.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/spi_target.sv
// Byte-wide SPI mode-0 target, MSB first. All SPI pins are oversampled by clk;
// the CPU side uses load/unload strobes with a single TX holding register.
module spi_target #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sclk,
   input  logic             ssn,
   input  logic             mosi,
   output logic             miso,
   input  logic             load,
   input  logic [WIDTH-1:0] datain,
   input  logic             unload,
   output logic [WIDTH-1:0] dataout,
   output logic             rx_valid,
   output logic             tx_empty,
   output logic             overrun,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state, state_nxt;

   logic [2:0]       sclk_sync, ssn_sync;
   logic [1:0]       mosi_sync;
   logic [WIDTH-1:0] holding, tx_shift, rx_shift;
   logic [CW-1:0]    count;
   logic             reload_pending;

   // ssn synchroniser resets high so reset release never looks like a select
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         ssn_sync  <= '1;
         mosi_sync <= '0;
      end else begin
         sclk_sync <= {sclk_sync[1:0], sclk};
         ssn_sync  <= {ssn_sync[1:0], ssn};
         mosi_sync <= {mosi_sync[0], mosi};
      end
   end

   logic sclk_rise, sclk_fall, ssn_fall, ssn_rise;
   assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
   assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
   assign ssn_fall  = ~ssn_sync[1] & ssn_sync[2];
   assign ssn_rise  = ssn_sync[1] & ~ssn_sync[2];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ssn_fall) state_nxt = SHIFT;
         SHIFT:   if (ssn_rise) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   logic frame_start, frame_abort, bit_rise, bit_fall, byte_done, tx_reload;
   assign frame_start = (state == IDLE) & ssn_fall;
   assign frame_abort = (state == SHIFT) & ssn_rise;
   assign bit_rise    = (state == SHIFT) & ~ssn_rise & sclk_rise;
   assign bit_fall    = (state == SHIFT) & ~ssn_rise & sclk_fall;
   assign byte_done   = bit_rise & (count == LAST);
   assign tx_reload   = frame_start | (bit_fall & reload_pending);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         holding        <= '1;
         tx_shift       <= '0;
         rx_shift       <= '0;
         count          <= '0;
         reload_pending <= 1'b0;
         dataout        <= '0;
         rx_valid       <= 1'b0;
         overrun        <= 1'b0;
         tx_empty       <= 1'b1;
      end else begin
         // an empty holding register sends all ones
         if (tx_reload)     tx_shift <= tx_empty ? '1 : holding;
         else if (bit_fall) tx_shift <= tx_shift << 1;

         if (bit_rise) rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync[1]};

         if (frame_start || frame_abort || byte_done) count <= '0;
         else if (bit_rise)                           count <= count + 1'b1;

         if (frame_start || frame_abort)  reload_pending <= 1'b0;
         else if (byte_done)              reload_pending <= 1'b1;
         else if (bit_fall)               reload_pending <= 1'b0;

         // a completing byte beats a simultaneous unload
         if (byte_done) begin
            dataout  <= {rx_shift[WIDTH-2:0], mosi_sync[1]};
            rx_valid <= 1'b1;
            if (rx_valid && !unload) overrun <= 1'b1;
         end else if (unload) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end

         // load after reload: transfer takes the old holding value
         if (load) begin
            holding  <= datain;
            tx_empty <= 1'b0;
         end else if (tx_reload) begin
            tx_empty <= 1'b1;
         end
      end
   end

   assign miso = (state == SHIFT) & tx_shift[WIDTH-1];
   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a mode-0 master model with sclk period 10 clk.
module tb_spi_target;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sclk = 1'b0, ssn = 1'b1, mosi = 1'b0;
   logic       miso;
   logic       load = 1'b0, unload = 1'b0;
   logic [7:0] datain = '0;
   logic [7:0] dataout;
   logic       rx_valid, tx_empty, overrun, busy;

   int n_tests = 0;
   int n_fail  = 0;

   spi_target #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .ssn(ssn), .mosi(mosi), .miso(miso),
      .load(load), .datain(datain), .unload(unload), .dataout(dataout),
      .rx_valid(rx_valid), .tx_empty(tx_empty), .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cpu_load(input logic [7:0] d);
      @(negedge clk); load = 1'b1; datain = d;
      @(negedge clk); load = 1'b0;
   endtask

   task automatic cpu_unload();
      @(negedge clk); unload = 1'b1;
      @(negedge clk); unload = 1'b0;
   endtask

   task automatic ssn_low();
      @(negedge clk); ssn = 1'b0;
      wait_clk(6);
   endtask

   task automatic ssn_high();
      wait_clk(6);
      ssn = 1'b1;
      wait_clk(6);
   endtask

   // Sends n bits of tx MSB first; miso captured on each rising edge.
   // ul pulses unload on the clk edge where the last bit completes.
   task automatic spi_bits(input logic [7:0] tx, input int n, input bit ul,
                           output logic [7:0] rx);
      rx = '0;
      for (int i = 0; i < n; i++) begin
         mosi = tx[7-i];
         wait_clk(5);
         rx[7-i] = miso;
         sclk = 1'b1;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ul && i == n-1 && k == 1) unload = 1'b1;
            if (k == 2) unload = 1'b0;
         end
         sclk = 1'b0;
      end
   endtask

   logic [7:0] rx;

   initial begin
      // reset state
      #13;
      chk("rst_miso", miso, 0);
      chk("rst_dataout", dataout, 8'h00);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_tx_empty", tx_empty, 1);
      chk("rst_overrun", overrun, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_clk(4);

      // basic frame
      cpu_load(8'hA5);
      chk("t1_tx_full", tx_empty, 0);
      ssn_low();
      chk("t1_busy", busy, 1);
      chk("t1_tx_empty", tx_empty, 1);
      spi_bits(8'h3C, 8, 1'b0, rx);
      ssn_high();
      chk("t1_miso", rx, 8'hA5);
      chk("t1_dataout", dataout, 8'h3C);
      chk("t1_rx_valid", rx_valid, 1);
      chk("t1_idle", busy, 0);
      cpu_unload();
      chk("t1_unload", rx_valid, 0);

      // no load: all ones
      ssn_low();
      spi_bits(8'h81, 8, 1'b0, rx);
      ssn_high();
      chk("t2_miso", rx, 8'hFF);
      chk("t2_dataout", dataout, 8'h81);
      cpu_unload();

      // two bytes in one frame, overrun
      cpu_load(8'h5A);
      ssn_low();
      spi_bits(8'h12, 8, 1'b0, rx);
      chk("t3_miso0", rx, 8'h5A);
      chk("t3_mid_dataout", dataout, 8'h12);
      spi_bits(8'h34, 8, 1'b0, rx);
      chk("t3_miso1", rx, 8'hFF);
      ssn_high();
      chk("t3_overrun", overrun, 1);
      chk("t3_dataout", dataout, 8'h34);
      chk("t3_rx_valid", rx_valid, 1);
      cpu_unload();
      chk("t3_unl_rx_valid", rx_valid, 0);
      chk("t3_unl_overrun", overrun, 0);

      // abort after 5 bits, then a clean frame
      ssn_low();
      spi_bits(8'hFF, 5, 1'b0, rx);
      ssn_high();
      chk("t4_rx_valid", rx_valid, 0);
      chk("t4_dataout", dataout, 8'h34);
      chk("t4_busy", busy, 0);
      ssn_low();
      spi_bits(8'h55, 8, 1'b0, rx);
      ssn_high();
      chk("t4_dataout2", dataout, 8'h55);
      chk("t4_rx_valid2", rx_valid, 1);

      // unload coincident with completion
      ssn_low();
      spi_bits(8'h99, 8, 1'b1, rx);
      ssn_high();
      chk("t5_rx_valid", rx_valid, 1);
      chk("t5_overrun", overrun, 0);
      chk("t5_dataout", dataout, 8'h99);

      // async reset mid-frame
      cpu_load(8'h0F);
      ssn_low();
      spi_bits(8'hAA, 3, 1'b0, rx);
      chk("t6_pre_busy", busy, 1);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("t6_miso", miso, 0);
      chk("t6_dataout", dataout, 8'h00);
      chk("t6_rx_valid", rx_valid, 0);
      chk("t6_tx_empty", tx_empty, 1);
      chk("t6_overrun", overrun, 0);
      chk("t6_busy", busy, 0);
      ssn = 1'b1; sclk = 1'b0;
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(4);
      ssn_low();
      spi_bits(8'hC3, 8, 1'b0, rx);
      ssn_high();
      chk("t6_miso_after", rx, 8'hFF);
      chk("t6_dataout_after", dataout, 8'hC3);
      chk("t6_rx_valid_after", rx_valid, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
